// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// Optional watchdog abort in WAIT_DONE when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int NBITS          = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*NBITS-1:0]   din,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    timeout,
    output logic                    tx_start,
    output logic [NBITS-1:0]        tx_din,
    input  logic                    tx_done
);

    localparam int IW   = $clog2(NREQ);
    localparam int CMAX = (GAP_CYCLES > TIMEOUT_CYCLES) ?
                          GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        GAP
    } state_t;

    state_t        state;
    logic [IW-1:0] rr;
    logic [IW-1:0] win;
    logic [IW-1:0] rr_next;
    logic [CW-1:0] gap_cnt;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [CW-1:0] wd_cnt;
`endif

    // Winner search: scan offsets high to low so the smallest offset from rr wins.
    always_comb begin
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr) + k) % NREQ]) begin
                win = IW'((int'(rr) + k) % NREQ);
            end
        end
        rr_next = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    end

    // Frame sequencing FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr       <= '0;
            gap_cnt  <= '0;
            ack      <= '0;
            done     <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            tx_start <= 1'b0;
            tx_din   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd_cnt   <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            ack      <= '0;
            done     <= '0;
            tx_start <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        ack      <= NREQ'(1) << win;
                        tx_din   <= din[win*NBITS +: NBITS];
                        grant_id <= win;
                        busy     <= 1'b1;
                        rr       <= rr_next;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_start <= 1'b1;
                    state    <= WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    wd_cnt   <= '0;
`endif
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        done <= NREQ'(1) << grant_id;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        timeout <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == CW'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_TX_ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=4, GAP=2, TIMEOUT=16).
// Expected grants are queued when requests are driven and popped on ack.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int NB   = 8;
    localparam int GAP  = 2;
    localparam int TMO  = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [31:0]     din = '0;
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] done;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout;
    logic            tx_start;
    logic [NB-1:0]   tx_din;
    logic            tx_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    typedef struct {
        int         id;
        logic [7:0] b;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .NBITS(NB),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .din(din),
        .ack(ack),
        .done(done),
        .grant_id(grant_id),
        .busy(busy),
        .timeout(timeout),
        .tx_start(tx_start),
        .tx_din(tx_din),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (done != 0) done_seen++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        tx_done = 1'b0;
        exp_q.delete();
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_ack(output int id, output logic [7:0] b,
                            output bit ok, output int nack);
        ok = 1'b0;
        id = -1;
        b = '0;
        nack = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (done != 0) done_seen++;
            if (ack != 0) begin
                ok = 1'b1;
                b = tx_din;
                nack = $countones(ack);
                for (int k = 0; k < NREQ; k++) if (ack[k]) id = k;
            end
        end
    endtask

    task automatic pulse_done(input int delay);
        tick(delay);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic pop_exp(output exp_t e);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '{-2, 8'h00};
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({ack, done, grant_id, busy, timeout, tx_start, tx_din} !== '0) begin
            errors++;
            $display("FAIL reset_state got ack=%b done=%b gid=%0d busy=%b to=%b st=%b din=%h want all 0",
                     ack, done, grant_id, busy, timeout, tx_start, tx_din);
        end
    endtask

    task automatic test_single();
        int id; logic [7:0] b; bit ok; int n; exp_t e;
        do_reset();
        din = 32'h0000_00A5;
        req = 4'b0001;
        exp_q.push_back('{0, 8'hA5});
        wait_ack(id, b, ok, n);
        req = '0;
        pop_exp(e);
        checks++;
        if (!ok || id != e.id || b !== e.b || ack !== 4'b0001 || !busy || tx_start) begin
            errors++;
            $display("FAIL single_grant got ok=%0d id=%0d byte=%h ack=%b busy=%b st=%b want id=%0d byte=%h",
                     ok, id, b, ack, busy, tx_start, e.id, e.b);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || ack !== 4'b0) begin
            errors++;
            $display("FAIL single_start got st=%b ack=%b want st=1 ack=0", tx_start, ack);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_start_len got st=%b want 0", tx_start);
        end
        pulse_done(18);
        checks++;
        if (done !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_done got done=%b busy=%b want 0001/1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap1 got done=%b busy=%b want 0000/1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_gap_end got busy=%b want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int id; logic [7:0] b; bit ok; int n; exp_t e;
        do_reset();
        din = 32'h4433_2211;
        req = 4'b1111;
        exp_q.push_back('{0, 8'h11});
        exp_q.push_back('{1, 8'h22});
        exp_q.push_back('{2, 8'h33});
        exp_q.push_back('{3, 8'h44});
        exp_q.push_back('{0, 8'h11});
        for (int f = 0; f < 5; f++) begin
            wait_ack(id, b, ok, n);
            pop_exp(e);
            checks++;
            if (!ok || id != e.id || b !== e.b || n != 1) begin
                errors++;
                $display("FAIL rr_grant%0d got ok=%0d id=%0d byte=%h nack=%0d want id=%0d byte=%h nack=1",
                         f, ok, id, b, n, e.id, e.b);
            end
            @(negedge clk);
            pulse_done(9);
            checks++;
            if (done !== (4'b0001 << e.id)) begin
                errors++;
                $display("FAIL rr_done%0d got %b want %b", f, done, 4'b0001 << e.id);
            end
        end
        req = '0;
        tick(3);
    endtask

    task automatic test_pointer_wrap();
        int id; logic [7:0] b; bit ok; int n; exp_t e;
        do_reset();
        din = 32'h4433_2211;
        req = 4'b1000;
        exp_q.push_back('{3, 8'h44});
        wait_ack(id, b, ok, n);
        req = '0;
        pop_exp(e);
        checks++;
        if (!ok || id != e.id || b !== e.b) begin
            errors++;
            $display("FAIL wrap_first got id=%0d byte=%h want id=%0d byte=%h", id, b, e.id, e.b);
        end
        @(negedge clk);
        pulse_done(2);
        req = 4'b1010;
        exp_q.push_back('{1, 8'h22});
        exp_q.push_back('{3, 8'h44});
        for (int f = 0; f < 2; f++) begin
            wait_ack(id, b, ok, n);
            if (ok && id >= 0) req[id] = 1'b0;
            pop_exp(e);
            checks++;
            if (!ok || id != e.id || b !== e.b) begin
                errors++;
                $display("FAIL wrap_grant%0d got id=%0d byte=%h want id=%0d byte=%h",
                         f, id, b, e.id, e.b);
            end
            @(negedge clk);
            pulse_done(2);
        end
        tick(3);
    endtask

    task automatic test_spurious();
        int id; logic [7:0] b; bit ok; int n; exp_t e;
        do_reset();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        checks++;
        if (done !== 4'b0 || busy !== 1'b0 || ack !== 4'b0) begin
            errors++;
            $display("FAIL spur_idle got done=%b busy=%b ack=%b want 0/0/0", done, busy, ack);
        end
        tick(2);
        checks++;
        if (done !== 4'b0 || busy !== 1'b0 || ack !== 4'b0) begin
            errors++;
            $display("FAIL spur_idle_hold got done=%b busy=%b ack=%b want 0/0/0", done, busy, ack);
        end
        din = 32'h0000_00C3;
        req = 4'b0001;
        exp_q.push_back('{0, 8'hC3});
        wait_ack(id, b, ok, n);
        req = '0;
        pop_exp(e);
        checks++;
        if (!ok || id != e.id || b !== e.b) begin
            errors++;
            $display("FAIL spur_grant got id=%0d byte=%h want id=%0d byte=%h", id, b, e.id, e.b);
        end
        @(negedge clk);
        pulse_done(3);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        checks++;
        if (done !== 4'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL spur_gap got done=%b busy=%b want 0000/1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL spur_gap_end got busy=%b want 0", busy);
        end
        tick(3);
        checks++;
        if (ack !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spur_no_grant got ack=%b busy=%b want 0/0", ack, busy);
        end
    endtask

    task automatic test_reset_mid();
        int id; logic [7:0] b; bit ok; int n; exp_t e; int ds;
        do_reset();
        din = 32'h0033_0011;
        req = 4'b0001;
        exp_q.push_back('{0, 8'h11});
        wait_ack(id, b, ok, n);
        req = '0;
        pop_exp(e);
        checks++;
        if (!ok || id != e.id || b !== e.b) begin
            errors++;
            $display("FAIL mid_grant got id=%0d byte=%h want id=%0d byte=%h", id, b, e.id, e.b);
        end
        tick(4);
        reset = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tx_done = 1'b0;
        checks++;
        if ({ack, done, grant_id, busy, timeout, tx_start, tx_din} !== '0) begin
            errors++;
            $display("FAIL mid_reset got ack=%b done=%b gid=%0d busy=%b st=%b din=%h want all 0",
                     ack, done, grant_id, busy, tx_start, tx_din);
        end
        ds = done_seen;
        tick(4);
        checks++;
        if (done_seen != ds) begin
            errors++;
            $display("FAIL mid_no_done got %0d done pulses want 0", done_seen - ds);
        end
        req = 4'b0101;
        exp_q.push_back('{0, 8'h11});
        exp_q.push_back('{2, 8'h33});
        for (int f = 0; f < 2; f++) begin
            wait_ack(id, b, ok, n);
            if (ok && id >= 0) req[id] = 1'b0;
            pop_exp(e);
            checks++;
            if (!ok || id != e.id || b !== e.b) begin
                errors++;
                $display("FAIL mid_after%0d got id=%0d byte=%h want id=%0d byte=%h",
                         f, id, b, e.id, e.b);
            end
            @(negedge clk);
            pulse_done(3);
        end
        tick(3);
    endtask

    task automatic test_timeout();
        int id; logic [7:0] b; bit ok; int n; exp_t e; int ds;
        do_reset();
        din = 32'h0000_225A;
        req = 4'b0001;
        exp_q.push_back('{0, 8'h5A});
        wait_ack(id, b, ok, n);
        req = '0;
        pop_exp(e);
        checks++;
        if (!ok || id != e.id || b !== e.b) begin
            errors++;
            $display("FAIL to_grant got id=%0d byte=%h want id=%0d byte=%h", id, b, e.id, e.b);
        end
        ds = done_seen;
`ifdef UART_TX_ARB_TIMEOUT_EN
        begin
            int cyc;
            cyc = -1;
            for (int c = 1; c <= 40 && cyc < 0; c++) begin
                @(negedge clk);
                if (done != 0) done_seen++;
                if (timeout) cyc = c;
            end
            checks++;
            if (cyc != TMO + 1 || done_seen != ds) begin
                errors++;
                $display("FAIL to_pulse got cycle=%0d dones=%0d want cycle=%0d dones=0",
                         cyc, done_seen - ds, TMO + 1);
            end
            @(negedge clk);
            checks++;
            if (timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_width got timeout=%b want 0", timeout);
            end
            req = 4'b0011;
            exp_q.push_back('{1, 8'h22});
            wait_ack(id, b, ok, n);
            req = '0;
            pop_exp(e);
            checks++;
            if (!ok || id != e.id || b !== e.b) begin
                errors++;
                $display("FAIL to_next got id=%0d byte=%h want id=%0d byte=%h", id, b, e.id, e.b);
            end
        end
`else
        begin
            int tos;
            tos = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (done != 0) done_seen++;
                if (timeout !== 1'b0) tos++;
            end
            checks++;
            if (tos != 0 || busy !== 1'b1 || done_seen != ds) begin
                errors++;
                $display("FAIL to_disabled got timeouts=%0d busy=%b dones=%0d want 0/1/0",
                         tos, busy, done_seen - ds);
            end
        end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_spurious();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
